// File: rtl/tinker_mem_arbiter.sv
// tinker_mem_arbiter: round-robin sharing of one memory port between fetch, load and store,
// one outstanding access at a time, with a watchdog that aborts unacknowledged accesses.
`timescale 1ns/1ps
module tinker_mem_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   output logic              ld_gnt,
   output logic              ld_rvalid,
   output logic [63:0]       ld_rdata,
   input  logic              st_req,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [63:0]       st_data,
   output logic              st_gnt,
   output logic              st_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic              mem_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   input  logic [63:0]       mem_rdata,
   input  logic              mem_ack,
   output logic              timeout_err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [1:0] SEL_IF = 2'd0;
   localparam logic [1:0] SEL_LD = 2'd1;
   localparam logic [1:0] SEL_ST = 2'd2;

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 2);

   logic [1:0]        state_q, state_d;
   logic [1:0]        rr_q, win_q, pick, offset;
   logic              first_q, any_req, launch, ack_now, abort_now;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [63:0]       wdata_q, ld_rdata_q, cap_data;
   logic [31:0]       if_rdata_q;
   logic              we_q, size_q, terr_q;
   logic [2:0]        reqs, req_rot, pick_sum;
   logic [5:0]        req_dbl;

   // Rotate requests so bit 0 is the requester the RR pointer names, then priority-pick.
   assign reqs    = {st_req, ld_req, if_req};
   assign req_dbl = {reqs, reqs};
   assign req_rot = 3'(req_dbl >> rr_q);

   always_comb begin
      any_req = |req_rot;
      if (req_rot[0]) begin
         offset = 2'd0;
      end else if (req_rot[1]) begin
         offset = 2'd1;
      end else begin
         offset = 2'd2;
      end
      pick_sum = {1'b0, rr_q} + {1'b0, offset};
      pick     = (pick_sum >= 3'd3) ? 2'(pick_sum - 3'd3) : pick_sum[1:0];
   end

   assign launch    = (state_q == ST_IDLE) && any_req;
   assign ack_now   = (state_q == ST_BUSY) && mem_ack;
   assign abort_now = (state_q == ST_BUSY) && !mem_ack && (TIMEOUT != 0) &&
                      (cnt_q == CNT_W'(TIMEOUT - 1));
   assign cap_data  = ack_now ? mem_rdata : 64'd0;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (any_req) state_d = ST_BUSY;
         ST_BUSY: if (ack_now || abort_now) state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         rr_q    <= SEL_IF;
         win_q   <= SEL_IF;
         first_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         first_q <= launch;
         if (launch) begin
            win_q <= pick;
            cnt_q <= '0;
         end else if (state_q == ST_BUSY) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (state_q == ST_RESP) begin
            rr_q <= (win_q == SEL_ST) ? SEL_IF : win_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         size_q  <= 1'b0;
      end else if (launch) begin
         we_q    <= (pick == SEL_ST);
         size_q  <= (pick != SEL_IF);
         wdata_q <= (pick == SEL_ST) ? st_data : 64'd0;
         case (pick)
            SEL_IF:  addr_q <= if_addr;
            SEL_LD:  addr_q <= ld_addr;
            default: addr_q <= st_addr;
         endcase
      end
   end

   // Aborted accesses return zero data; timeout_err is sticky until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         if_rdata_q <= '0;
         ld_rdata_q <= '0;
         terr_q     <= 1'b0;
      end else begin
         if (ack_now || abort_now) begin
            if (win_q == SEL_IF) if_rdata_q <= cap_data[31:0];
            if (win_q == SEL_LD) ld_rdata_q <= cap_data;
         end
         if (abort_now) terr_q <= 1'b1;
      end
   end

   assign if_gnt      = (state_q == ST_BUSY) && first_q && (win_q == SEL_IF);
   assign ld_gnt      = (state_q == ST_BUSY) && first_q && (win_q == SEL_LD);
   assign st_gnt      = (state_q == ST_BUSY) && first_q && (win_q == SEL_ST);
   assign if_rvalid   = (state_q == ST_RESP) && (win_q == SEL_IF);
   assign ld_rvalid   = (state_q == ST_RESP) && (win_q == SEL_LD);
   assign st_done     = (state_q == ST_RESP) && (win_q == SEL_ST);
   assign if_rdata    = if_rdata_q;
   assign ld_rdata    = ld_rdata_q;
   assign mem_req     = (state_q == ST_BUSY);
   assign mem_we      = we_q;
   assign mem_size    = size_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// Bench for tinker_mem_arbiter: directed scenarios plus random traffic, checked by a
// transaction-level model whose expected grants/responses are drained by a monitor.
`timescale 1ns/1ps
module tb_tinker_mem_arbiter;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        if_req = 1'b0, ld_req = 1'b0, st_req = 1'b0;
   logic [31:0] if_addr = '0, ld_addr = '0, st_addr = '0;
   logic [63:0] st_data = '0, mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic        if_gnt, if_rvalid, ld_gnt, ld_rvalid, st_gnt, st_done;
   logic        mem_req, mem_we, mem_size, timeout_err;
   logic [31:0] if_rdata, mem_addr;
   logic [63:0] ld_rdata, mem_wdata;

   tinker_mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
      .ld_rdata(ld_rdata),
      .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_gnt(st_gnt),
      .st_done(st_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      int          who;
      logic [31:0] addr;
      logic        we;
      logic        size;
      logic [63:0] wdata;
   } gnt_t;

   typedef struct {
      int unsigned cyc;
      int          who;
      logic [63:0] data;
   } rsp_t;

   gnt_t gq[$];
   rsp_t rq[$];

   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0;

   // Reference model state (0 idle, 1 memory access, 2 response).
   int          m_phase = 0;
   int          m_rr = 0;
   int          m_wait = 0;
   gnt_t        m_cur;
   logic        m_terr = 1'b0;
   logic [31:0] m_if_rdata = '0;
   logic [63:0] m_ld_rdata = '0;

   // Stimulus knobs.
   int          pct = 0;
   logic        hold_all = 1'b0;
   int          fixed_target = 1;
   logic        allow_to = 1'b0;
   logic        fixed_rdata_en = 1'b0;
   logic [63:0] fixed_rdata = '0;
   int          ack_target = 1;
   int          busy_seen = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic int enc(input logic [2:0] v);
      case (v)
         3'b001:  return 0;
         3'b010:  return 1;
         3'b100:  return 2;
         default: return 7;
      endcase
   endfunction

   function automatic logic req_of(input int w);
      case (w)
         0:       return if_req;
         1:       return ld_req;
         default: return st_req;
      endcase
   endfunction

   function automatic logic [31:0] addr_of(input int w);
      case (w)
         0:       return if_addr;
         1:       return ld_addr;
         default: return st_addr;
      endcase
   endfunction

   task automatic model_reset();
      gq.delete();
      rq.delete();
      m_phase    = 0;
      m_rr       = 0;
      m_wait     = 0;
      m_terr     = 1'b0;
      m_if_rdata = '0;
      m_ld_rdata = '0;
   endtask

   // Advance the model over the clock edge that just happened, using the inputs present at it.
   task automatic model_step();
      gnt_t g;
      rsp_t r;
      int   w;
      case (m_phase)
         0: begin
            w = -1;
            for (int k = 0; k < 3; k++) begin
               if (w < 0 && req_of((m_rr + k) % 3)) w = (m_rr + k) % 3;
            end
            if (w >= 0) begin
               g.cyc   = cyc;
               g.who   = w;
               g.addr  = addr_of(w);
               g.we    = (w == 2);
               g.size  = (w != 0);
               g.wdata = (w == 2) ? st_data : 64'd0;
               m_cur   = g;
               gq.push_back(g);
               m_phase = 1;
               m_wait  = 0;
            end
         end
         1: begin
            m_wait++;
            if (mem_ack || (TIMEOUT != 0 && m_wait == int'(TIMEOUT))) begin
               r.cyc  = cyc;
               r.who  = m_cur.who;
               r.data = mem_ack ? mem_rdata : 64'd0;
               if (!mem_ack) m_terr = 1'b1;
               if (r.who == 0) m_if_rdata = r.data[31:0];
               if (r.who == 1) m_ld_rdata = r.data;
               rq.push_back(r);
               m_phase = 2;
            end
         end
         default: begin
            m_rr    = (m_cur.who + 1) % 3;
            m_phase = 0;
         end
      endcase
   endtask

   task automatic req_drive(input logic gnt_seen, inout logic req, inout logic [31:0] addr,
                            output logic fresh);
      fresh = 1'b0;
      if (gnt_seen) begin
         req   = hold_all;
         addr  = $urandom;
         fresh = 1'b1;
      end else if (!req && ($urandom_range(99) < pct)) begin
         req   = 1'b1;
         addr  = $urandom;
         fresh = 1'b1;
      end
   endtask

   task automatic drive();
      logic fresh;
      req_drive(if_gnt, if_req, if_addr, fresh);
      req_drive(ld_gnt, ld_req, ld_addr, fresh);
      req_drive(st_gnt, st_req, st_addr, fresh);
      if (fresh) st_data = {$urandom, $urandom};
      if (mem_req) begin
         busy_seen++;
      end else begin
         busy_seen = 0;
         if (fixed_target >= 0) ack_target = fixed_target;
         else if (allow_to && $urandom_range(99) < 5) ack_target = 1000;
         else ack_target = $urandom_range(0, 4);
      end
      mem_ack   = (ack_target == 0) || (mem_req && busy_seen >= ack_target);
      mem_rdata = fixed_rdata_en ? fixed_rdata : {$urandom, $urandom};
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      #1;
      if (!reset) model_step();
      drive();
   endtask

   // Monitor: drains expected grants/responses when due and checks per-cycle port state.
   logic [2:0] mon_g, mon_r;
   gnt_t       mon_eg;
   rsp_t       mon_er;

   always @(negedge clk) begin
      if (!reset) begin
         mon_g = {st_gnt, ld_gnt, if_gnt};
         mon_r = {st_done, ld_rvalid, if_rvalid};
         if (gq.size() > 0 && gq[0].cyc == cyc) begin
            mon_eg = gq.pop_front();
            check("gnt_who", enc(mon_g), mon_eg.who);
            check("gnt_mem_addr", mem_addr, mon_eg.addr);
            check("gnt_we_size", {mem_we, mem_size}, {mon_eg.we, mon_eg.size});
            check("gnt_wdata", mem_wdata, mon_eg.wdata);
         end else begin
            check("gnt_quiet", mon_g, 0);
         end
         if (rq.size() > 0 && rq[0].cyc == cyc) begin
            mon_er = rq.pop_front();
            check("rsp_who", enc(mon_r), mon_er.who);
            if (mon_er.who == 0) check("rsp_if_rdata", if_rdata, mon_er.data[31:0]);
            if (mon_er.who == 1) check("rsp_ld_rdata", ld_rdata, mon_er.data);
         end else begin
            check("rsp_quiet", mon_r, 0);
         end
         check("mem_req", mem_req, m_phase == 1);
         if (m_phase == 1) begin
            check("busy_addr", mem_addr, m_cur.addr);
            check("busy_we_size", {mem_we, mem_size}, {m_cur.we, m_cur.size});
            check("busy_wdata", mem_wdata, m_cur.wdata);
         end
         check("timeout_err", timeout_err, m_terr);
         check("if_rdata_hold", if_rdata, m_if_rdata);
         check("ld_rdata_hold", ld_rdata, m_ld_rdata);
      end
   end

   initial begin
      int n;
      model_reset();
      // Reset held with every requester asserting.
      if_req = 1'b1; if_addr = 32'h0000_1000;
      ld_req = 1'b1; ld_addr = 32'h0000_2000;
      st_req = 1'b1; st_addr = 32'h0000_3000; st_data = 64'hA5A5_0000_5A5A_FFFF;
      repeat (3) step();
      check("rst_ctrl", {if_gnt, if_rvalid, ld_gnt, ld_rvalid, st_gnt, st_done,
                         mem_req, mem_we, mem_size, timeout_err}, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_ld_rdata", ld_rdata, 0);
      @(negedge clk); #2 reset = 1'b0;
      repeat (15) step();

      // All requesters held high, memory always acknowledging.
      hold_all = 1'b1; fixed_target = 0;
      if_req = 1'b1; ld_req = 1'b1; st_req = 1'b1;
      repeat (30) step();
      hold_all = 1'b0; fixed_target = 1;
      repeat (12) step();

      // Store with a five-cycle memory latency.
      fixed_target = 5;
      st_req = 1'b1; st_addr = 32'h0008_0000; st_data = 64'hDEAD_BEEF_0123_4567;
      repeat (12) step();

      // Load with known return data.
      fixed_target = 2; fixed_rdata_en = 1'b1; fixed_rdata = 64'h1122_3344_5566_7788;
      ld_req = 1'b1; ld_addr = 32'h0000_2008;
      repeat (8) step();
      fixed_rdata_en = 1'b0;

      // Load that the memory never acknowledges, then good accesses.
      fixed_target = 1000;
      ld_req = 1'b1; ld_addr = 32'h0000_4000;
      repeat (24) step();
      fixed_target = 1;
      if_req = 1'b1; st_req = 1'b1; ld_req = 1'b1;
      repeat (15) step();

      // Random traffic.
      allow_to = 1'b1; fixed_target = -1;
      for (int c = 0; c < 10; c++) begin
         pct      = $urandom_range(10, 80);
         hold_all = ($urandom_range(3) == 0);
         repeat (200) step();
      end
      hold_all = 1'b0; allow_to = 1'b0; pct = 0; fixed_target = 1;
      repeat (25) step();

      // Reset in the middle of a memory access.
      pct = 40; fixed_target = 3;
      n = 0;
      while (m_phase != 1 && n < 60) begin
         step();
         n++;
      end
      check("midreset_busy_before", mem_req, 1);
      pct = 0;
      #1 reset = 1'b1;
      #1;
      check("midreset_mem_req", mem_req, 0);
      check("midreset_pulses", {if_gnt, if_rvalid, ld_gnt, ld_rvalid, st_gnt, st_done}, 0);
      model_reset();
      if_req = 1'b1; if_addr = 32'h0000_0040;
      ld_req = 1'b1; st_req = 1'b1;
      repeat (2) step();
      check("midreset_quiet", {if_rvalid, ld_rvalid, st_done, mem_req, timeout_err}, 0);
      @(negedge clk); #2 reset = 1'b0;
      repeat (15) step();

      repeat (20) step();
      check("grant_queue_drained", gq.size(), 0);
      check("resp_queue_drained", rq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
